// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with an accumulator and
// valid/ready handshakes on both sides. Stage 1 holds bit/group P/G, stage 2 the result.
module cla_pipe_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [WIDTH-1:0] acc
);

  localparam int unsigned NG = WIDTH / GROUP;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_ACC  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  op_e              w_op;
  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;
  logic             w_c0;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_g;
  logic [NG-1:0]    w_gp;
  logic [NG-1:0]    w_gg;
  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;
  logic             w_advance;
  logic             w_s1_en;
  logic             w_hazard;
  logic             w_accept;
  logic             w_s1_writes_acc;

  logic             r_s1_valid;
  op_e              r_s1_op;
  logic             r_s1_c0;
  logic [WIDTH-1:0] r_s1_p;
  logic [WIDTH-1:0] r_s1_g;
  logic [NG-1:0]    r_s1_gp;
  logic [NG-1:0]    r_s1_gg;

  logic             r_s2_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic [WIDTH-1:0] r_acc;

  assign w_op = op_e'(op);

  // Operand selection at acceptance
  always_comb begin
    w_x  = a;
    w_y  = b;
    w_c0 = cin;
    case (w_op)
      OP_SUB:  begin w_y = ~b;       w_c0 = 1'b1; end
      OP_ACC:  begin w_x = r_acc;    w_y  = a;    end
      OP_LOAD: begin w_y = '0;       w_c0 = 1'b0; end
      default: ;
    endcase
  end

  assign w_p = w_x ^ w_y;
  assign w_g = w_x & w_y;

  // Group propagate/generate
  always_comb begin
    logic gp_t;
    logic gg_t;
    w_gp = '0;
    w_gg = '0;
    for (int unsigned k = 0; k < NG; k++) begin
      gp_t = 1'b1;
      gg_t = 1'b0;
      for (int unsigned j = 0; j < GROUP; j++) begin
        gg_t = w_g[k*GROUP+j] | (w_p[k*GROUP+j] & gg_t);
        gp_t = gp_t & w_p[k*GROUP+j];
      end
      w_gp[k] = gp_t;
      w_gg[k] = gg_t;
    end
  end

  // Group carries by parallel prefix (c0 is the generate of a virtual group -1),
  // then bit carries within each group.
  always_comb begin
    logic [NG:0] pp;
    logic [NG:0] gg;
    logic        c;
    gg = {r_s1_gg, r_s1_c0};
    pp = {r_s1_gp, 1'b0};
    for (int d = 1; d <= int'(NG); d = d * 2) begin
      for (int i = int'(NG); i >= d; i--) begin
        gg[i] = gg[i] | (pp[i] & gg[i-d]);
        pp[i] = pp[i] & pp[i-d];
      end
    end
    w_carry = '0;
    for (int unsigned k = 0; k < NG; k++) begin
      c = gg[k];
      for (int unsigned j = 0; j < GROUP; j++) begin
        w_carry[k*GROUP+j] = c;
        c = r_s1_g[k*GROUP+j] | (r_s1_p[k*GROUP+j] & c);
      end
    end
    w_carry[WIDTH] = gg[NG];
    w_sum  = r_s1_p ^ w_carry[WIDTH-1:0];
    w_cout = w_carry[WIDTH];
    w_ovf  = w_carry[WIDTH-1] ^ w_carry[WIDTH];
    if (r_s1_op == OP_LOAD) begin
      w_cout = 1'b0;
      w_ovf  = 1'b0;
    end
  end

  assign w_s1_writes_acc = (r_s1_op == OP_ACC) || (r_s1_op == OP_LOAD);
  assign w_advance       = !r_s2_valid || out_ready;
  assign w_s1_en         = w_advance || !r_s1_valid;
  // An accumulate must see the accumulator updated by the beat ahead of it
  assign w_hazard        = in_valid && (w_op == OP_ACC) && r_s1_valid && w_s1_writes_acc;
  assign in_ready        = w_s1_en && !w_hazard;
  assign w_accept        = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= OP_ADD;
      r_s1_c0    <= 1'b0;
      r_s1_p     <= '0;
      r_s1_g     <= '0;
      r_s1_gp    <= '0;
      r_s1_gg    <= '0;
    end else if (w_s1_en) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_op <= w_op;
        r_s1_c0 <= w_c0;
        r_s1_p  <= w_p;
        r_s1_g  <= w_g;
        r_s1_gp <= w_gp;
        r_s1_gg <= w_gg;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_sum      <= '0;
      r_cout     <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (w_advance) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_sum  <= w_sum;
        r_cout <= w_cout;
        r_ovf  <= w_ovf;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (w_advance && r_s1_valid && w_s1_writes_acc) begin
      r_acc <= w_sum;
    end
  end

  assign out_valid = r_s2_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign acc       = r_acc;

endmodule
